// File: rtl/pmem_sched_if.sv
// Requester-side and memory-side signals of the physical-memory scheduler.
// master = caches/prefetcher/memory side, slave = the scheduler.
interface pmem_sched_if #(
  parameter int unsigned BEATS = 4
);
  localparam int unsigned LINE_W = 64 * BEATS;

  logic [31:0]       inst_addr;
  logic              inst_read;
  logic [LINE_W-1:0] inst_rdata;
  logic              inst_resp;

  logic [31:0]       data_addr;
  logic              data_read;
  logic              data_write;
  logic [LINE_W-1:0] data_wdata;
  logic [LINE_W-1:0] data_rdata;
  logic              data_resp;

  logic [31:0]       pf_addr;
  logic              pf_read;
  logic [LINE_W-1:0] pf_rdata;
  logic              pf_resp;

  logic [31:0]       pmem_addr;
  logic              pmem_read;
  logic              pmem_write;
  logic [63:0]       pmem_wdata;
  logic [63:0]       pmem_rdata;
  logic              pmem_resp;

  modport master (
    output inst_addr, inst_read, data_addr, data_read, data_write, data_wdata,
           pf_addr, pf_read, pmem_rdata, pmem_resp,
    input  inst_rdata, inst_resp, data_rdata, data_resp, pf_rdata, pf_resp,
           pmem_addr, pmem_read, pmem_write, pmem_wdata
  );

  modport slave (
    input  inst_addr, inst_read, data_addr, data_read, data_write, data_wdata,
           pf_addr, pf_read, pmem_rdata, pmem_resp,
    output inst_rdata, inst_resp, data_rdata, data_resp, pf_rdata, pf_resp,
           pmem_addr, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/pmem_sched.sv
// Arbitrates icache, dcache and prefetcher onto one burst memory port and
// converts between whole lines and 64-bit beats; one line transaction at a time.
module pmem_sched #(
  parameter int unsigned BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  pmem_sched_if.slave bus
);
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned LINE_W = BEAT_W * BEATS;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BSH    = $clog2(BEAT_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OWN_INST = 2'd0;
  localparam logic [1:0] OWN_DATA = 2'd1;
  localparam logic [1:0] OWN_PF   = 2'd2;

  logic [1:0]           state, state_nxt;
  logic [1:0]           owner, owner_nxt;
  logic                 rr_data, rr_data_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
  logic [31:0]          addr, addr_nxt;
  logic [LINE_W-1:0]    wbuf, wbuf_nxt;
  logic [LINE_W-1:0]    line, line_nxt;
  logic [BEAT_W-1:0]    wdata, wdata_nxt;
  logic                 rd, rd_nxt;
  logic                 wr, wr_nxt;
  logic [2:0]           resp, resp_nxt;
  logic                 inst_req, data_req, last_beat;
  logic [CNT_W+BSH-1:0] rd_off, wr_off;

  assign inst_req  = bus.inst_read;
  assign data_req  = bus.data_read | bus.data_write;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign rd_off    = {cnt, BSH'(0)};
  assign wr_off    = {cnt_inc, BSH'(0)};

  // Next-state and datapath; the write beat register is preloaded with the
  // following beat so pmem_wdata is always a flop output.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_data_nxt = rr_data;
    cnt_nxt     = cnt;
    addr_nxt    = addr;
    wbuf_nxt    = wbuf;
    line_nxt    = line;
    wdata_nxt   = wdata;
    rd_nxt      = rd;
    wr_nxt      = wr;
    resp_nxt    = 3'b000;

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (inst_req && !(data_req && rr_data)) begin
          state_nxt   = S_READ;
          owner_nxt   = OWN_INST;
          rr_data_nxt = 1'b1;
          rd_nxt      = 1'b1;
          addr_nxt    = bus.inst_addr & ~32'h1F;
        end else if (data_req) begin
          owner_nxt   = OWN_DATA;
          rr_data_nxt = 1'b0;
          addr_nxt    = bus.data_addr & ~32'h1F;
          if (bus.data_write) begin
            state_nxt = S_WRITE;
            wr_nxt    = 1'b1;
            wbuf_nxt  = bus.data_wdata;
            wdata_nxt = bus.data_wdata[BEAT_W-1:0];
          end else begin
            state_nxt = S_READ;
            rd_nxt    = 1'b1;
          end
        end else if (bus.pf_read) begin
          state_nxt = S_READ;
          owner_nxt = OWN_PF;
          rd_nxt    = 1'b1;
          addr_nxt  = bus.pf_addr & ~32'h1F;
        end
      end

      S_READ, S_WRITE: begin
        if (bus.pmem_resp) begin
          cnt_nxt = cnt_inc;
          if (state == S_READ) begin
            line_nxt[rd_off +: BEAT_W] = bus.pmem_rdata;
          end else begin
            wdata_nxt = wbuf[wr_off +: BEAT_W];
          end
          if (last_beat) begin
            state_nxt = S_DONE;
            rd_nxt    = 1'b0;
            wr_nxt    = 1'b0;
            cnt_nxt   = '0;
            resp_nxt  = 3'b001 << owner;
          end
        end
      end

      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      owner   <= OWN_INST;
      rr_data <= 1'b0;
      cnt     <= '0;
      addr    <= '0;
      wbuf    <= '0;
      line    <= '0;
      wdata   <= '0;
      rd      <= 1'b0;
      wr      <= 1'b0;
      resp    <= 3'b000;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      rr_data <= rr_data_nxt;
      cnt     <= cnt_nxt;
      addr    <= addr_nxt;
      wbuf    <= wbuf_nxt;
      line    <= line_nxt;
      wdata   <= wdata_nxt;
      rd      <= rd_nxt;
      wr      <= wr_nxt;
      resp    <= resp_nxt;
    end
  end

  // Every requester sees the shared line buffer; only its resp qualifies it.
  assign bus.pmem_addr  = addr;
  assign bus.pmem_read  = rd;
  assign bus.pmem_write = wr;
  assign bus.pmem_wdata = wdata;
  assign bus.inst_rdata = line;
  assign bus.data_rdata = line;
  assign bus.pf_rdata   = line;
  assign bus.inst_resp  = resp[0];
  assign bus.data_resp  = resp[1];
  assign bus.pf_resp    = resp[2];
endmodule

// File: tb/tb_pmem_sched.sv
// Scenario bench for pmem_sched: a beat-level memory responder plus a
// transaction-level model of grant order and line contents.
module tb_pmem_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   rr_data_fav = 1'b0;
  int   first_gap = 0;
  int   beat_gap = 0;
  bit   rand_gaps = 1'b0;
  logic [255:0] mem [bit [31:0]];

  pmem_sched_if bus ();
  pmem_sched dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [63:0] beat_of(input logic [255:0] l, input int i);
    return 64'(l >> (64 * i));
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    l = '0;
    for (int i = 0; i < 4; i++) l = l | (256'({a, 32'hBEEF_0000 | 32'(i)}) << (64 * i));
    return l;
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l = (l << 32) | 256'($urandom);
    return l;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return {20'h0, 12'($urandom)};
  endfunction

  // Reference arbitration: inst/data alternate, pf only when both are idle.
  task automatic model_grant(input bit i, input bit d, input bit p, output logic [2:0] who);
    if (i && d)  who = rr_data_fav ? 3'b010 : 3'b001;
    else if (i)  who = 3'b001;
    else if (d)  who = 3'b010;
    else if (p)  who = 3'b100;
    else         who = 3'b000;
    if (who == 3'b001) rr_data_fav = 1'b1;
    else if (who == 3'b010) rr_data_fav = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drop_all();
    bus.inst_read  = 1'b0;
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    bus.pf_read    = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output logic [2:0] who, output logic [255:0] line,
                           output logic saw_rd, output logic saw_wr, output logic [31:0] a);
    bit done, got_a;
    who = 3'b000; line = '0; saw_rd = 1'b0; saw_wr = 1'b0; a = '0;
    done = 1'b0; got_a = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      if (bus.pmem_read)  saw_rd = 1'b1;
      if (bus.pmem_write) saw_wr = 1'b1;
      if ((bus.pmem_read || bus.pmem_write) && !got_a) begin
        a = bus.pmem_addr;
        got_a = 1'b1;
      end
      who = {bus.pf_resp, bus.data_resp, bus.inst_resp};
      if (who != 3'b000) begin
        line = who[0] ? bus.inst_rdata : (who[1] ? bus.data_rdata : bus.pf_rdata);
        done = 1'b1;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drop_all();
    step();
    step();
    rst = 1'b0;
    rr_data_fav = 1'b0;
    step();
  endtask

  // Memory side: serves one burst at a time with configurable gaps.
  initial begin
    bit busy;
    int beat, gap;
    logic [31:0] baddr;
    logic [255:0] bline, wline;
    busy = 1'b0; beat = 0; gap = 0; baddr = '0; bline = '0; wline = '0;
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !(bus.pmem_read || bus.pmem_write)) begin
        busy = 1'b0;
        bus.pmem_resp = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1; beat = 0; baddr = bus.pmem_addr; bline = get_line(baddr); wline = '0;
          gap = rand_gaps ? int'($urandom_range(0, 2)) : first_gap;
        end
        if (gap > 0) begin
          gap--;
          bus.pmem_resp = 1'b0;
        end else begin
          bus.pmem_resp = 1'b1;
          if (bus.pmem_read) bus.pmem_rdata = beat_of(bline, beat);
          else wline = wline | (256'(bus.pmem_wdata) << (64 * beat));
          beat++;
          gap = rand_gaps ? int'($urandom_range(0, 2)) : beat_gap;
          if (beat == 4) begin
            busy = 1'b0;
            if (bus.pmem_write) mem[baddr] = wline;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    drop_all();
    bus.inst_addr = '0; bus.data_addr = '0; bus.pf_addr = '0; bus.data_wdata = '0;
    step();
    step();
    vectors++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin miscompares++;
      $display("FAIL reset_strobes: got %b, expected 00", {bus.pmem_read, bus.pmem_write}); end
    vectors++; if (bus.pmem_addr !== 32'h0) begin miscompares++;
      $display("FAIL reset_pmem_addr: got %h, expected 0", bus.pmem_addr); end
    vectors++; if (bus.pmem_wdata !== 64'h0) begin miscompares++;
      $display("FAIL reset_pmem_wdata: got %h, expected 0", bus.pmem_wdata); end
    vectors++; if ({bus.pf_resp, bus.data_resp, bus.inst_resp} !== 3'b000) begin miscompares++;
      $display("FAIL reset_resp: got %b, expected 000", {bus.pf_resp, bus.data_resp, bus.inst_resp}); end
    vectors++; if ((bus.inst_rdata | bus.data_rdata | bus.pf_rdata) !== 256'h0) begin miscompares++;
      $display("FAIL reset_rdata: got %h, expected 0", bus.inst_rdata | bus.data_rdata | bus.pf_rdata); end
    rst = 1'b0;
    rr_data_fav = 1'b0;
    step();
    step();
    vectors++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin miscompares++;
      $display("FAIL idle_strobes: got %b, expected 00", {bus.pmem_read, bus.pmem_write}); end
  endtask

  task automatic test_inst_read();
    logic [2:0] exp;
    logic [255:0] l;
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    mem[32'h0000_1220] = l;
    rand_gaps = 1'b0; first_gap = 2; beat_gap = 0;
    bus.inst_addr = 32'h0000_1234;
    bus.inst_read = 1'b1;
    model_grant(1'b1, 1'b0, 1'b0, exp);
    for (int c = 1; c <= 8; c++) begin
      step();
      vectors++; if (bus.pmem_read !== (c <= 6)) begin miscompares++;
        $display("FAIL inst_pmem_read_c%0d: got %b, expected %b", c, bus.pmem_read, (c <= 6)); end
      vectors++; if (bus.inst_resp !== (c == 7)) begin miscompares++;
        $display("FAIL inst_resp_c%0d: got %b, expected %b", c, bus.inst_resp, (c == 7)); end
      vectors++; if ({bus.data_resp, bus.pf_resp} !== 2'b00) begin miscompares++;
        $display("FAIL inst_other_resp_c%0d: got %b, expected 00", c, {bus.data_resp, bus.pf_resp}); end
      if (c == 1) begin
        vectors++; if (bus.pmem_addr !== 32'h0000_1220) begin miscompares++;
          $display("FAIL inst_pmem_addr: got %h, expected 00001220", bus.pmem_addr); end
      end
      if (c == 7) begin
        vectors++; if (bus.inst_rdata !== l) begin miscompares++;
          $display("FAIL inst_rdata: got %h, expected %h", bus.inst_rdata, l); end
        bus.inst_read = 1'b0;
      end
    end
  endtask

  task automatic test_write_gaps();
    logic [255:0] w, line;
    logic [2:0] exp, who;
    logic rd, wr;
    logic [31:0] a;
    int seen, last;
    bit done;
    w = {64'hDDCC_BBAA_9988_7766, 64'h5544_3322_1100_FFEE,
         64'hEEDD_CCBB_AA99_8877, 64'h6655_4433_2211_0100};
    rand_gaps = 1'b0; first_gap = 0; beat_gap = 2;
    bus.data_addr = 32'h0000_8040; bus.data_wdata = w; bus.data_write = 1'b1;
    model_grant(1'b0, 1'b1, 1'b0, exp);
    seen = 0; last = -10; done = 1'b0;
    for (int c = 1; c <= 30 && !done; c++) begin
      step();
      if (seen < 4) begin
        vectors++; if (bus.pmem_write !== 1'b1) begin miscompares++;
          $display("FAIL wr_strobe_c%0d: got %b, expected 1", c, bus.pmem_write); end
        vectors++; if (bus.pmem_wdata !== beat_of(w, seen)) begin miscompares++;
          $display("FAIL wr_beat%0d_c%0d: got %h, expected %h", seen, c, bus.pmem_wdata, beat_of(w, seen)); end
        if (bus.pmem_resp) begin
          seen++;
          if (seen == 4) last = c;
        end
        if (c == 1) begin
          bus.data_wdata = rnd_line();
          bus.data_addr = 32'h0000_9999;
        end
      end else begin
        vectors++; if (bus.data_resp !== (c == last + 1)) begin miscompares++;
          $display("FAIL wr_resp_c%0d: got %b, expected %b", c, bus.data_resp, (c == last + 1)); end
        vectors++; if (bus.pmem_write !== 1'b0) begin miscompares++;
          $display("FAIL wr_strobe_done_c%0d: got %b, expected 0", c, bus.pmem_write); end
        done = 1'b1;
      end
    end
    bus.data_write = 1'b0;
    vectors++; if (!done) begin miscompares++;
      $display("FAIL wr_timeout: got %0d beats, expected 4 and a resp", seen); end
    vectors++; if (get_line(32'h0000_8040) !== w) begin miscompares++;
      $display("FAIL wr_mem_line: got %h, expected %h", get_line(32'h0000_8040), w); end
    step();
    rand_gaps = 1'b1;
    bus.data_addr = 32'h0000_8051; bus.data_read = 1'b1;
    model_grant(1'b0, 1'b1, 1'b0, exp);
    wait_resp(60, who, line, rd, wr, a);
    bus.data_read = 1'b0;
    vectors++; if (who !== 3'b010 || line !== w) begin miscompares++;
      $display("FAIL wr_readback: got who=%b line=%h, expected who=010 line=%h", who, line, w); end
    step();
  endtask

  task automatic test_alternate();
    logic [2:0] exp, who, want;
    logic [255:0] line, expl;
    logic rd, wr;
    logic [31:0] a;
    apply_reset();
    rand_gaps = 1'b1;
    bus.inst_addr = 32'h0000_0104; bus.data_addr = 32'h0000_02A8;
    bus.inst_read = 1'b1; bus.data_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      model_grant(1'b1, 1'b1, 1'b0, exp);
      wait_resp(60, who, line, rd, wr, a);
      want = (k % 2 == 0) ? 3'b001 : 3'b010;
      expl = get_line((k % 2 == 0) ? 32'h0000_0100 : 32'h0000_02A0);
      vectors++; if (who !== want) begin miscompares++;
        $display("FAIL alt_grant%0d: got %b, expected %b", k, who, want); end
      vectors++; if (line !== expl) begin miscompares++;
        $display("FAIL alt_line%0d: got %h, expected %h", k, line, expl); end
      if (k == 3) drop_all();
      else begin
        if (k % 2 == 0) bus.inst_read = 1'b0; else bus.data_read = 1'b0;
        step();
        bus.inst_read = 1'b1; bus.data_read = 1'b1;
      end
    end
    step();
  endtask

  task automatic test_pf_priority();
    logic [2:0] exp, who;
    logic [255:0] line;
    logic rd, wr;
    logic [31:0] a;
    rand_gaps = 1'b1;
    bus.data_addr = 32'h0000_0440; bus.pf_addr = 32'h0000_0460;
    bus.data_read = 1'b1; bus.pf_read = 1'b1;
    model_grant(1'b0, 1'b1, 1'b1, exp);
    wait_resp(60, who, line, rd, wr, a);
    bus.data_read = 1'b0;
    vectors++; if (who !== exp || line !== get_line(32'h0000_0440)) begin miscompares++;
      $display("FAIL pf_data_first: got who=%b line=%h, expected who=%b", who, line, exp); end
    model_grant(1'b0, 1'b0, 1'b1, exp);
    wait_resp(60, who, line, rd, wr, a);
    bus.pf_read = 1'b0;
    vectors++; if (who !== 3'b100 || line !== get_line(32'h0000_0460)) begin miscompares++;
      $display("FAIL pf_second: got who=%b line=%h, expected who=100", who, line); end
    step();
    bus.pf_addr = 32'h0000_0480; bus.inst_addr = 32'h0000_04A0;
    bus.pf_read = 1'b1;
    model_grant(1'b0, 1'b0, 1'b1, exp);
    step();
    step();
    bus.inst_read = 1'b1;
    wait_resp(60, who, line, rd, wr, a);
    bus.pf_read = 1'b0;
    vectors++; if (who !== 3'b100 || line !== get_line(32'h0000_0480)) begin miscompares++;
      $display("FAIL pf_not_preempted: got who=%b line=%h, expected who=100", who, line); end
    model_grant(1'b1, 1'b0, 1'b0, exp);
    wait_resp(60, who, line, rd, wr, a);
    bus.inst_read = 1'b0;
    vectors++; if (who !== 3'b001 || line !== get_line(32'h0000_04A0)) begin miscompares++;
      $display("FAIL pf_then_inst: got who=%b line=%h, expected who=001", who, line); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    logic [2:0] exp, who;
    logic [255:0] line;
    logic rd, wr;
    logic [31:0] a;
    int resps;
    rand_gaps = 1'b0; first_gap = 0; beat_gap = 0;
    bus.inst_addr = 32'h0000_3000; bus.inst_read = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    drop_all();
    #1;
    vectors++; if (bus.pmem_read !== 1'b0) begin miscompares++;
      $display("FAIL rst_async_drop: got %b, expected 0", bus.pmem_read); end
    resps = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      resps += int'(bus.inst_resp) + int'(bus.data_resp) + int'(bus.pf_resp);
    end
    rst = 1'b0;
    rr_data_fav = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      resps += int'(bus.inst_resp) + int'(bus.data_resp) + int'(bus.pf_resp);
    end
    vectors++; if (resps !== 0) begin miscompares++;
      $display("FAIL rst_no_resp: got %0d resps, expected 0", resps); end
    rand_gaps = 1'b1;
    bus.inst_addr = 32'h0000_5008; bus.inst_read = 1'b1;
    model_grant(1'b1, 1'b0, 1'b0, exp);
    wait_resp(60, who, line, rd, wr, a);
    bus.inst_read = 1'b0;
    vectors++; if (who !== 3'b001 || line !== get_line(32'h0000_5000)) begin miscompares++;
      $display("FAIL rst_fresh_line: got who=%b line=%h, expected who=001 line=%h", who, line,
               get_line(32'h0000_5000)); end
    step();
  endtask

  task automatic test_rw_both();
    logic [2:0] exp, who;
    logic [255:0] line, wd;
    logic rd, wr;
    logic [31:0] a;
    int resps;
    rand_gaps = 1'b1;
    wd = rnd_line();
    bus.data_addr = 32'h0000_7000; bus.data_wdata = wd;
    bus.data_read = 1'b1; bus.data_write = 1'b1;
    model_grant(1'b0, 1'b1, 1'b0, exp);
    wait_resp(60, who, line, rd, wr, a);
    drop_all();
    vectors++; if (who !== 3'b010) begin miscompares++;
      $display("FAIL rw_who: got %b, expected 010", who); end
    vectors++; if ({rd, wr} !== 2'b01) begin miscompares++;
      $display("FAIL rw_strobes: got rd=%b wr=%b, expected rd=0 wr=1", rd, wr); end
    vectors++; if (get_line(32'h0000_7000) !== wd) begin miscompares++;
      $display("FAIL rw_mem: got %h, expected %h", get_line(32'h0000_7000), wd); end
    resps = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      resps += int'(bus.data_resp);
    end
    vectors++; if (resps !== 0) begin miscompares++;
      $display("FAIL rw_single_resp: got %0d extra resps, expected 0", resps); end
  endtask

  task automatic test_random();
    logic i, d, w, p;
    logic [2:0] exp, who;
    logic [255:0] line, expl, wd;
    logic rd, wr;
    logic [31:0] a, expa;
    rand_gaps = 1'b1;
    for (int r = 0; r < 40; r++) begin
      i = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1));
      if (!(i || d || w || p)) p = 1'b1;
      bus.inst_addr = rnd_addr(); bus.data_addr = rnd_addr(); bus.pf_addr = rnd_addr();
      wd = rnd_line();
      bus.data_wdata = wd;
      bus.inst_read = i; bus.data_read = d; bus.data_write = w; bus.pf_read = p;
      model_grant(i, d || w, p, exp);
      expa = exp[0] ? bus.inst_addr : (exp[1] ? bus.data_addr : bus.pf_addr);
      expa = expa & ~32'h1F;
      expl = (exp[1] && w) ? wd : get_line(expa);
      step();
      bus.inst_addr = rnd_addr(); bus.data_addr = rnd_addr(); bus.pf_addr = rnd_addr();
      bus.data_wdata = rnd_line();
      wait_resp(60, who, line, rd, wr, a);
      drop_all();
      vectors++; if (who !== exp) begin miscompares++;
        $display("FAIL rnd%0d_who: got %b, expected %b", r, who, exp); end
      vectors++; if (a !== expa) begin miscompares++;
        $display("FAIL rnd%0d_addr: got %h, expected %h", r, a, expa); end
      if (exp[1] && w) begin
        vectors++; if ({rd, wr} !== 2'b01 || get_line(expa) !== expl) begin miscompares++;
          $display("FAIL rnd%0d_write: got rd=%b wr=%b mem=%h, expected rd=0 wr=1 mem=%h",
                   r, rd, wr, get_line(expa), expl); end
      end else begin
        vectors++; if ({rd, wr} !== 2'b10 || line !== expl) begin miscompares++;
          $display("FAIL rnd%0d_read: got rd=%b wr=%b line=%h, expected rd=1 wr=0 line=%h",
                   r, rd, wr, line, expl); end
      end
      step();
    end
  endtask

  initial begin
    drop_all();
    test_reset();
    test_inst_read();
    test_write_gaps();
    test_alternate();
    test_pf_priority();
    test_reset_mid_burst();
    test_rw_both();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
